// File: rtl/ucode_store.sv
// Writable microcode store: words are loaded in LOAD, then issued one per cycle
// from the control unit's microaddress, stalling on memory microwords until mem_ready.
module ucode_store #(
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   uaddr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [CW+6:0]   wr_data,
    input  logic            start,
    input  logic            mem_ready,
    output logic            br,
    output logic [AW-1:0]   na,
    output logic [CW-1:0]   ctrl,
    output logic            mem_req,
    output logic            hold,
    output logic            running
);
    localparam int WW    = CW + 7;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   store_q [DEPTH];
    logic [WW-1:0]   word_q;
    logic            rd_en;
    logic            word_mem;

    assign word_mem = word_q[CW];

    // Storage is never reset so a program survives a control-unit restart.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == S_LOAD && wr_en) begin
            store_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // The issued word is only ever replaced by a read; it stays zero throughout LOAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (rd_en) begin
            word_q <= store_q[uaddr];
        end
    end

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (word_mem && !mem_ready) begin
                    state_d = S_WAIT;
                end else begin
                    rd_en = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    state_d = S_RUN;
                    rd_en   = 1'b1;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    assign br      = word_q[WW-1];
    assign na      = word_q[CW+AW:CW+1];
    assign ctrl    = word_q[CW-1:0];
    assign mem_req = word_mem;
    assign running = (state_q != S_LOAD);
    // Combinational so the control unit freezes in the very cycle a memory word appears.
    assign hold    = (state_q == S_WAIT) ||
                     (state_q == S_RUN && word_mem && !mem_ready);

endmodule

// File: tb/tb_ucode_store.sv
// Self-checking bench for ucode_store: directed scenarios plus a randomized run
// compared against an abstract issue/stall model of the microcode store.
module tb_ucode_store;
    localparam int AW = 5;
    localparam int CW = 16;
    localparam int WW = CW + 7;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   uaddr;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [WW-1:0]   wr_data;
    logic            start;
    logic            mem_ready;
    logic            br;
    logic [AW-1:0]   na;
    logic [CW-1:0]   ctrl;
    logic            mem_req;
    logic            hold;
    logic            running;

    int checks   = 0;
    int failures = 0;

    // Reference model: program contents, whether issuing, whether stalled, issued word.
    logic [WW-1:0] m_mem [32];
    bit            m_run;
    bit            m_wait;
    logic [WW-1:0] m_word;

    ucode_store #(.AW(AW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uaddr     (uaddr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .mem_ready (mem_ready),
        .br        (br),
        .na        (na),
        .ctrl      (ctrl),
        .mem_req   (mem_req),
        .hold      (hold),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WW-1:0] mkword(input logic b, input logic [AW-1:0] n,
                                             input logic m, input logic [CW-1:0] c);
        return {b, n, m, c};
    endfunction

    task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                         input logic [WW-1:0] wd, input logic st,
                         input logic [AW-1:0] ua, input logic mr);
        rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd;
        start = st; uaddr = ua; mem_ready = mr;
    endtask

    // One clock: model follows the rules using the inputs sampled at the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_run = 0; m_wait = 0; m_word = '0;
        end else if (!m_run) begin
            if (wr_en) m_mem[wr_addr] = wr_data;
            if (start) m_run = 1;
        end else if (m_word[CW] && !mem_ready) begin
            m_wait = 1;
        end else begin
            m_wait = 0;
            m_word = m_mem[uaddr];
        end
        @(negedge clk);
    endtask

    function automatic logic exp_hold();
        return m_run && m_word[CW] && (m_wait || !mem_ready);
    endfunction

    task automatic test_reset();
        drive(0, 1, 5'd3, 23'h7FFFFF, 1, 5'd0, 0);
        tick(); tick();
        drive(0, 0, 5'd0, '0, 0, 5'd0, 0);
        #1;
        checks++;
        if ({br, na, ctrl, mem_req, hold, running} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {br, na, ctrl, mem_req, hold, running});
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 32; i++) begin
            drive(1, 1, i[AW-1:0], WW'($urandom), 0, 5'd0, 0);
            tick();
        end
        drive(1, 1, 5'd0,  mkword(0, 5'd1, 0, 16'h0003), 0, 5'd0, 0); tick();
        drive(1, 1, 5'd1,  mkword(1, 5'd0, 0, 16'h0104), 0, 5'd0, 0); tick();
        drive(1, 1, 5'd5,  mkword(0, 5'd6, 0, 16'h0505), 0, 5'd0, 0); tick();
        drive(1, 1, 5'd11, mkword(0, 5'd12, 0, 16'h1111), 0, 5'd0, 0); tick();
        drive(1, 1, 5'd22, mkword(0, 5'd5, 1, 16'hA5A5), 0, 5'd0, 0); tick();
        drive(1, 1, 5'd23, mkword(1, 5'd5, 1, 16'h2323), 0, 5'd0, 0); tick();
        checks++;
        if (running !== 1'b0 || ctrl !== 16'h0) begin
            failures++;
            $display("FAIL load_idle running=%b ctrl=%h want running=0 ctrl=0000", running, ctrl);
        end
    endtask

    task automatic test_basic();
        drive(1, 0, 5'd0, '0, 1, 5'd0, 0); tick();
        drive(1, 0, 5'd0, '0, 0, 5'd0, 0); #1;
        checks++;
        if (running !== 1'b1 || ctrl !== 16'h0 || hold !== 1'b0) begin
            failures++;
            $display("FAIL start_run running=%b ctrl=%h hold=%b want 1/0000/0", running, ctrl, hold);
        end
        tick();
        checks++;
        if (ctrl !== 16'h0003 || na !== 5'd1 || br !== 1'b0) begin
            failures++;
            $display("FAIL word0 ctrl=%h na=%0d br=%b want 0003/1/0", ctrl, na, br);
        end
        drive(1, 0, 5'd0, '0, 0, 5'd1, 0); tick();
        checks++;
        if (ctrl !== 16'h0104 || na !== 5'd0 || br !== 1'b1) begin
            failures++;
            $display("FAIL word1 ctrl=%h na=%0d br=%b want 0104/0/1", ctrl, na, br);
        end
    endtask

    task automatic test_wait();
        int low_holds;
        low_holds = 0;
        drive(1, 0, 5'd0, '0, 0, 5'd22, 0); tick();
        // mem_ready low for three cycles; uaddr moves but must be ignored.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 5'd0, '0, 0, 5'd7, 0); #1;
            if (hold === 1'b1 && mem_req === 1'b1 && ctrl === 16'hA5A5 && na === 5'd5) low_holds++;
            tick();
        end
        checks++;
        if (low_holds != 3) begin
            failures++;
            $display("FAIL wait_stall stalled_cycles=%0d want 3", low_holds);
        end
        drive(1, 0, 5'd0, '0, 0, 5'd5, 1); #1;
        checks++;
        if (hold !== 1'b1 || ctrl !== 16'hA5A5) begin
            failures++;
            $display("FAIL wait_release hold=%b ctrl=%h want 1/a5a5", hold, ctrl);
        end
        tick(); #1;
        checks++;
        if (ctrl !== 16'h0505 || hold !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL wait_next ctrl=%h hold=%b mem_req=%b want 0505/0/0", ctrl, hold, mem_req);
        end
    endtask

    task automatic test_no_wait();
        int holds;
        holds = 0;
        drive(1, 0, 5'd0, '0, 0, 5'd23, 1); #1;
        if (hold === 1'b1) holds++;
        tick(); #1;
        if (hold === 1'b1) holds++;
        checks++;
        if (ctrl !== 16'h2323 || mem_req !== 1'b1 || br !== 1'b1) begin
            failures++;
            $display("FAIL nowait_word ctrl=%h mem_req=%b br=%b want 2323/1/1", ctrl, mem_req, br);
        end
        drive(1, 0, 5'd0, '0, 0, 5'd5, 1); tick(); #1;
        if (hold === 1'b1) holds++;
        checks++;
        if (ctrl !== 16'h0505 || holds != 0) begin
            failures++;
            $display("FAIL nowait_next ctrl=%h hold_cycles=%0d want 0505/0", ctrl, holds);
        end
    endtask

    task automatic test_write_ignored();
        drive(1, 1, 5'd11, mkword(1, 5'd31, 1, 16'hDEAD), 0, 5'd0, 0); tick();
        drive(0, 1, 5'd11, mkword(1, 5'd31, 1, 16'hBEEF), 0, 5'd0, 0); tick();
        drive(1, 0, 5'd0, '0, 1, 5'd0, 0); tick();
        drive(1, 0, 5'd0, '0, 0, 5'd11, 0); tick();
        checks++;
        if (ctrl !== 16'h1111 || na !== 5'd12 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL run_write_ignored ctrl=%h na=%0d mem_req=%b want 1111/12/0", ctrl, na, mem_req);
        end
    endtask

    task automatic test_reset_in_wait();
        drive(1, 0, 5'd0, '0, 0, 5'd22, 0); tick(); tick();
        checks++;
        if (hold !== 1'b1 || running !== 1'b1) begin
            failures++;
            $display("FAIL enter_wait hold=%b running=%b want 1/1", hold, running);
        end
        drive(0, 0, 5'd0, '0, 0, 5'd22, 0); tick();
        drive(1, 0, 5'd0, '0, 0, 5'd22, 0); #1;
        checks++;
        if ({br, na, ctrl, mem_req, hold, running} !== '0) begin
            failures++;
            $display("FAIL wait_reset got=%h want 0", {br, na, ctrl, mem_req, hold, running});
        end
        drive(1, 0, 5'd0, '0, 1, 5'd1, 0); tick();
        drive(1, 0, 5'd0, '0, 0, 5'd1, 0); tick();
        checks++;
        if (ctrl !== 16'h0104 || br !== 1'b1) begin
            failures++;
            $display("FAIL resume_after_reset ctrl=%h br=%b want 0104/1", ctrl, br);
        end
    endtask

    task automatic test_write_start();
        drive(0, 0, 5'd0, '0, 0, 5'd0, 0); tick();
        drive(1, 1, 5'd0, mkword(0, 5'd0, 0, 16'hFFFF), 1, 5'd0, 0); tick();
        drive(1, 0, 5'd0, '0, 0, 5'd0, 0); tick();
        checks++;
        if (ctrl !== 16'hFFFF) begin
            failures++;
            $display("FAIL write_with_start ctrl=%h want ffff", ctrl);
        end
    endtask

    task automatic test_random();
        logic [WW:0]   got;
        logic [WW:0]   want;
        for (int cyc = 0; cyc < 600; cyc++) begin
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
                  AW'($urandom), WW'($urandom), ($urandom_range(0, 19) == 0),
                  AW'($urandom), ($urandom_range(0, 1) == 1));
            #1;
            got  = {br, na, ctrl, mem_req, hold, running};
            want = {m_word[WW-1], m_word[CW+AW:CW+1], m_word[CW-1:0],
                    m_word[CW], exp_hold(), m_run};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL random_cycle%0d got=%h want=%h", cyc, got, want);
            end
            tick();
        end
    endtask

    initial begin
        drive(0, 0, 5'd0, '0, 0, 5'd0, 0);
        m_run = 0; m_wait = 0; m_word = '0;
        @(negedge clk);
        test_reset();
        test_load();
        test_basic();
        test_wait();
        test_no_wait();
        test_write_ignored();
        test_reset_in_wait();
        test_write_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
